// File: rtl/counter_seq_pkg.sv
// Shared types and default sizes for the counter sequencer and its counter core.
package counter_seq_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/counter_core.sv
// Wrapping up/down counter with synchronous load; load wins over enable.
module counter_core #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             down,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= down ? (q - 1'b1) : (q + 1'b1);
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command sequencer: accepts start/len/dir, steps the counter core len times
// (pausable by hold), then pulses done for one cycle.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_down,
  input  logic             hold,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining;
  logic             dir;
  logic             fire;
  logic             step;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      remaining <= '0;
      dir       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        remaining <= cmd_len;
        dir       <= cmd_down;
      end else if (step) begin
        remaining <= remaining - 1'b1;
      end
    end
  end

  // Any encoding other than RUN/DONE (including 2'b11) behaves as IDLE.
  always_comb begin
    state_nxt = IDLE;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    fire      = 1'b0;
    step      = 1'b0;
    case (state)
      RUN: begin
        busy      = 1'b1;
        step      = !hold;
        state_nxt = RUN;
        if (step && remaining == LEN_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        cmd_ready = 1'b1;
        fire      = cmd_valid;
        state_nxt = IDLE;
        if (fire) state_nxt = (cmd_len != '0) ? RUN : DONE;
      end
    endcase
  end

  counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (fire),
    .load_val (cmd_start),
    .en       (step),
    .down     (dir),
    .q        (out)
  );

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: reset, up/down wrap, hold, zero length, abort.
module tb_counter_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_start = '0;
  logic [3:0] cmd_len = '0;
  logic       cmd_down = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] out;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  counter_seq_ctrl #(.WIDTH(3), .LEN_W(4)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_len   (cmd_len),
    .cmd_down  (cmd_down),
    .hold      (hold),
    .out       (out),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [2:0] s, input logic [3:0] l, input logic d);
    cmd_valid = 1'b1; cmd_start = s; cmd_len = l; cmd_down = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    cmd_valid = 1'b1; cmd_start = 3'($urandom); cmd_len = 4'($urandom);
    cmd_down = 1'($urandom); hold = 1'($urandom);
    RESET_N = 1'b0;
    #1;
    checks++; if (out !== 3'd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", out); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    tick(); tick();
    checks++; if (out !== 3'd0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_held out=%0d ready=%b exp 0/1", out, cmd_ready); end
    cmd_valid = 1'b0; hold = 1'b0;
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_up_wrap();
    logic [2:0] exp [4] = '{3'd7, 3'd0, 3'd1, 3'd2};
    send(3'd6, 4'd4, 1'b0);
    checks++; if (out !== 3'd6 || busy !== 1'b1) begin errors++; $display("FAIL up_load out=%0d busy=%b exp 6/1", out, busy); end
    for (int i = 0; i < 4; i++) begin
      logic eb;
      eb = (i < 3);
      tick();
      checks++; if (out !== exp[i]) begin errors++; $display("FAIL up_step%0d out=%0d exp=%0d", i, out, exp[i]); end
      checks++; if (busy !== eb || done !== !eb) begin errors++; $display("FAIL up_state%0d busy=%b done=%b exp %b/%b", i, busy, done, eb, !eb); end
    end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL up_ready_done got=%b exp=0", cmd_ready); end
    tick();
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || out !== 3'd2) begin errors++; $display("FAIL up_idle ready=%b done=%b out=%0d exp 1/0/2", cmd_ready, done, out); end
  endtask

  task automatic test_down_wrap();
    logic [2:0] exp [3] = '{3'd0, 3'd7, 3'd6};
    send(3'd1, 4'd3, 1'b1);
    checks++; if (out !== 3'd1) begin errors++; $display("FAIL dn_load out=%0d exp=1", out); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out !== exp[i]) begin errors++; $display("FAIL dn_step%0d out=%0d exp=%0d", i, out, exp[i]); end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL dn_done done=%b busy=%b exp 1/0", done, busy); end
    tick();
    checks++; if (cmd_ready !== 1'b1 || out !== 3'd6) begin errors++; $display("FAIL dn_idle ready=%b out=%0d exp 1/6", cmd_ready, out); end
  endtask

  task automatic test_hold();
    send(3'd0, 4'd3, 1'b0);
    checks++; if (out !== 3'd0) begin errors++; $display("FAIL hold_load out=%0d exp=0", out); end
    tick();
    checks++; if (out !== 3'd1) begin errors++; $display("FAIL hold_step1 out=%0d exp=1", out); end
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (out !== 3'd1 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL hold_frozen%0d out=%0d busy=%b done=%b exp 1/1/0", i, out, busy, done); end
    end
    hold = 1'b0;
    tick();
    checks++; if (out !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL hold_step2 out=%0d busy=%b exp 2/1", out, busy); end
    hold = 1'b1;
    tick();
    checks++; if (out !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL hold_frozen2 out=%0d busy=%b exp 2/1", out, busy); end
    hold = 1'b0;
    tick();
    checks++; if (out !== 3'd3 || done !== 1'b1) begin errors++; $display("FAIL hold_done out=%0d done=%b exp 3/1", out, done); end
    hold = 1'b1;
    tick();
    hold = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || out !== 3'd3) begin errors++; $display("FAIL hold_idle ready=%b done=%b out=%0d exp 1/0/3", cmd_ready, done, out); end
  endtask

  task automatic test_zero_len();
    send(3'd5, 4'd0, 1'b0);
    checks++; if (out !== 3'd5 || busy !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL zero_done out=%0d busy=%b done=%b ready=%b exp 5/0/1/0", out, busy, done, cmd_ready); end
    tick();
    checks++; if (out !== 3'd5 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_idle out=%0d busy=%b done=%b ready=%b exp 5/0/0/1", out, busy, done, cmd_ready); end
  endtask

  task automatic test_ignore();
    send(3'd2, 4'd3, 1'b0);
    cmd_valid = 1'b1; cmd_start = 3'd7; cmd_len = 4'd9; cmd_down = 1'b1;
    tick();
    checks++; if (out !== 3'd3 || cmd_ready !== 1'b0) begin errors++; $display("FAIL ign_step1 out=%0d ready=%b exp 3/0", out, cmd_ready); end
    tick();
    checks++; if (out !== 3'd4) begin errors++; $display("FAIL ign_step2 out=%0d exp=4", out); end
    tick();
    checks++; if (out !== 3'd5 || done !== 1'b1) begin errors++; $display("FAIL ign_done out=%0d done=%b exp 5/1", out, done); end
    tick();
    checks++; if (out !== 3'd5 || cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ign_no_accept_in_done out=%0d ready=%b busy=%b exp 5/1/0", out, cmd_ready, busy); end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_midrun();
    send(3'd3, 4'd5, 1'b0);
    tick();
    checks++; if (out !== 3'd4) begin errors++; $display("FAIL abort_step out=%0d exp=4", out); end
    #2 RESET_N = 1'b0;
    #1;
    checks++; if (out !== 3'd0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_async out=%0d ready=%b busy=%b done=%b exp 0/1/0/0", out, cmd_ready, busy, done); end
    tick();
    checks++; if (done !== 1'b0 || out !== 3'd0) begin errors++; $display("FAIL abort_nodone done=%b out=%0d exp 0/0", done, out); end
    #2 RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_after_reset();
    send(3'd4, 4'd2, 1'b1);
    checks++; if (out !== 3'd4 || busy !== 1'b1) begin errors++; $display("FAIL rec_load out=%0d busy=%b exp 4/1", out, busy); end
    tick();
    checks++; if (out !== 3'd3) begin errors++; $display("FAIL rec_step out=%0d exp=3", out); end
    tick();
    checks++; if (out !== 3'd2 || done !== 1'b1) begin errors++; $display("FAIL rec_done out=%0d done=%b exp 2/1", out, done); end
    tick();
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rec_idle ready=%b done=%b exp 1/0", cmd_ready, done); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_hold();
    test_zero_len();
    test_ignore();
    test_reset_midrun();
    test_after_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
